// File: rtl/jstk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jstk_pkg                                                             |
// | Shared constants and FSM encoding for the joystick conditioner.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package jstk_pkg;

  localparam logic [15:0] JSTK_CENTRE = 16'h8000;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } jstk_state_t;

endpackage
`default_nettype wire

// File: rtl/jstk_input_conditioner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jstk_input_conditioner_if                                            |
// | Sample bus from pmod_jstk2 and conditioned game-control outputs.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface jstk_input_conditioner_if;
  logic [15:0] x_position;
  logic [15:0] y_position;
  logic        btn_jstk;
  logic        btn_trigger;
  logic        data_valid;
  logic        read_in_progress;
  logic        start_read;
  logic [3:0]  dir;
  logic        move_strobe;
  logic        jstk_press;
  logic        jstk_release;
  logic        trig_press;
  logic        trig_release;
  logic        link_error;
  logic [15:0] sample_count;

  modport slave (
    input  x_position, y_position, btn_jstk, btn_trigger, data_valid, read_in_progress,
    output start_read, dir, move_strobe, jstk_press, jstk_release,
           trig_press, trig_release, link_error, sample_count
  );

  modport master (
    output x_position, y_position, btn_jstk, btn_trigger, data_valid, read_in_progress,
    input  start_read, dir, move_strobe, jstk_press, jstk_release,
           trig_press, trig_release, link_error, sample_count
  );
endinterface
`default_nettype wire

// File: rtl/jstk_axis_hyst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jstk_axis_hyst                                                       |
// | One-axis dead-zone hysteresis; outputs {neg,pos} active pair.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jstk_axis_hyst
  import jstk_pkg::*;
#(
  parameter logic [15:0] DZ_ENTER = 16'h3000,
  parameter logic [15:0] DZ_EXIT  = 16'h2000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [15:0] i_position,
  input  wire logic        i_accept,
  input  wire logic        i_clear,
  output logic [1:0]       o_active,
  output logic [1:0]       o_active_nxt
);

  logic [15:0] w_off;
  logic        w_neg;
  logic [15:0] w_abs;
  logic [15:0] w_mag;
  logic [1:0]  w_toward;
  logic [1:0]  r_active;

  assign w_off    = i_position ^ JSTK_CENTRE;
  assign w_neg    = w_off[15];
  assign w_abs    = w_neg ? (~w_off + 16'd1) : w_off;
  // Full-scale negative has no positive counterpart, so clamp it.
  assign w_mag    = (w_off == 16'h8000) ? 16'h7FFF : w_abs;
  assign w_toward = w_neg ? 2'b10 : 2'b01;

  always_comb begin
    o_active_nxt = r_active;
    if (r_active == 2'b00) begin
      if (w_mag > DZ_ENTER) o_active_nxt = w_toward;
    end else if (w_mag < DZ_EXIT) begin
      o_active_nxt = 2'b00;
    end else if ((w_mag > DZ_ENTER) && (w_toward != r_active)) begin
      o_active_nxt = w_toward;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 2'b00;
    end else if (i_accept) begin
      r_active <= o_active_nxt;
    end else if (i_clear) begin
      r_active <= 2'b00;
    end
  end

  assign o_active = r_active;

endmodule
`default_nettype wire

// File: rtl/jstk_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jstk_input_conditioner                                               |
// | Polls pmod_jstk2, turns samples into directions, repeats and pulses. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jstk_input_conditioner
  import jstk_pkg::*;
#(
  parameter int          POLL_DIV       = 1_000_000,
  parameter int          TIMEOUT_CYCLES = 500_000,
  parameter logic [15:0] DZ_ENTER       = 16'h3000,
  parameter logic [15:0] DZ_EXIT        = 16'h2000,
  parameter int          REPEAT_DELAY   = 25,
  parameter int          REPEAT_RATE    = 8
) (
  input wire logic                 clk,
  input wire logic                 reset,
  jstk_input_conditioner_if.slave  bus
);

  localparam int POLL_W = $clog2(POLL_DIV + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam int RATE_W = $clog2(REPEAT_RATE + 1);

  jstk_state_t       r_state;
  logic [POLL_W-1:0] r_poll_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic [RATE_W-1:0] r_rate;
  logic              r_dv_d;
  logic              r_start_read;
  logic              r_link_err;
  logic              r_move_strobe;
  logic              r_jstk_old, r_trig_old;
  logic              r_jstk_press, r_jstk_release, r_trig_press, r_trig_release;
  logic [15:0]       r_sample_count;

  logic              w_accept;
  logic              w_tick;
  logic              w_timeout;
  logic              w_clear;
  logic [1:0]        w_x_act, w_x_nxt, w_y_act, w_y_nxt;
  logic [3:0]        w_dir, w_dir_nxt;
  logic [HOLD_W-1:0] w_hold_inc;

  assign w_accept  = bus.data_valid & ~r_dv_d;
  assign w_tick    = (r_poll_cnt == POLL_W'(POLL_DIV - 1));
  assign w_timeout = (r_state == ST_WAIT) && !w_accept && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_clear   = w_timeout | r_link_err;

  jstk_axis_hyst #(.DZ_ENTER(DZ_ENTER), .DZ_EXIT(DZ_EXIT)) u_hyst_x (
    .clk          (clk),
    .reset        (reset),
    .i_position   (bus.x_position),
    .i_accept     (w_accept),
    .i_clear      (w_clear),
    .o_active     (w_x_act),
    .o_active_nxt (w_x_nxt)
  );

  jstk_axis_hyst #(.DZ_ENTER(DZ_ENTER), .DZ_EXIT(DZ_EXIT)) u_hyst_y (
    .clk          (clk),
    .reset        (reset),
    .i_position   (bus.y_position),
    .i_accept     (w_accept),
    .i_clear      (w_clear),
    .o_active     (w_y_act),
    .o_active_nxt (w_y_nxt)
  );

  always_comb begin
    w_dir                = 4'b0000;
    w_dir_nxt            = 4'b0000;
    w_dir[DIR_UP]        = w_y_act[0];
    w_dir[DIR_DOWN]      = w_y_act[1];
    w_dir[DIR_LEFT]      = w_x_act[1];
    w_dir[DIR_RIGHT]     = w_x_act[0];
    w_dir_nxt[DIR_UP]    = w_y_nxt[0];
    w_dir_nxt[DIR_DOWN]  = w_y_nxt[1];
    w_dir_nxt[DIR_LEFT]  = w_x_nxt[1];
    w_dir_nxt[DIR_RIGHT] = w_x_nxt[0];
  end

  assign w_hold_inc = r_hold + 1'b1;

  // Free-running poll timer: a tick that lands outside IDLE is simply dropped.
  always_ff @(posedge clk) begin
    if (reset)       r_poll_cnt <= '0;
    else if (w_tick) r_poll_cnt <= '0;
    else             r_poll_cnt <= r_poll_cnt + 1'b1;
  end

  // IDLE issues the request on the tick itself when the link is free,
  // passing through REQ only when pmod_jstk2 is still busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_to_cnt     <= '0;
      r_start_read <= 1'b0;
      r_link_err   <= 1'b0;
      r_dv_d       <= 1'b0;
    end else begin
      r_dv_d       <= bus.data_valid;
      r_start_read <= 1'b0;
      if (w_accept) r_link_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            if (!bus.read_in_progress) begin
              r_start_read <= 1'b1;
              r_to_cnt     <= '0;
              r_state      <= ST_WAIT;
            end else begin
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (!bus.read_in_progress) begin
            r_start_read <= 1'b1;
            r_to_cnt     <= '0;
            r_state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_accept) begin
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_link_err <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold         <= '0;
      r_rate         <= '0;
      r_move_strobe  <= 1'b0;
      r_jstk_old     <= 1'b0;
      r_trig_old     <= 1'b0;
      r_jstk_press   <= 1'b0;
      r_jstk_release <= 1'b0;
      r_trig_press   <= 1'b0;
      r_trig_release <= 1'b0;
      r_sample_count <= 16'd0;
    end else begin
      r_move_strobe  <= 1'b0;
      r_jstk_press   <= 1'b0;
      r_jstk_release <= 1'b0;
      r_trig_press   <= 1'b0;
      r_trig_release <= 1'b0;
      if (w_accept) begin
        r_sample_count <= r_sample_count + 16'd1;
        r_jstk_press   <=  bus.btn_jstk    & ~r_jstk_old;
        r_jstk_release <= ~bus.btn_jstk    &  r_jstk_old;
        r_trig_press   <=  bus.btn_trigger & ~r_trig_old;
        r_trig_release <= ~bus.btn_trigger &  r_trig_old;
        r_jstk_old     <= bus.btn_jstk;
        r_trig_old     <= bus.btn_trigger;
        if ((w_dir_nxt != w_dir) || (w_dir_nxt == 4'b0000)) begin
          r_hold        <= '0;
          r_rate        <= '0;
          r_move_strobe <= (w_dir_nxt != 4'b0000) && (w_dir_nxt != w_dir);
        end else if (r_hold != HOLD_W'(REPEAT_DELAY)) begin
          r_hold        <= w_hold_inc;
          r_rate        <= '0;
          r_move_strobe <= (w_hold_inc == HOLD_W'(REPEAT_DELAY));
        end else if (r_rate == RATE_W'(REPEAT_RATE - 1)) begin
          r_rate        <= '0;
          r_move_strobe <= 1'b1;
        end else begin
          r_rate <= r_rate + 1'b1;
        end
      end else if (w_clear) begin
        r_hold <= '0;
        r_rate <= '0;
      end
    end
  end

  assign bus.start_read   = r_start_read;
  assign bus.dir          = w_dir;
  assign bus.move_strobe  = r_move_strobe;
  assign bus.jstk_press   = r_jstk_press;
  assign bus.jstk_release = r_jstk_release;
  assign bus.trig_press   = r_trig_press;
  assign bus.trig_release = r_trig_release;
  assign bus.link_error   = r_link_err;
  assign bus.sample_count = r_sample_count;

endmodule
`default_nettype wire

// File: tb/tb_jstk_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jstk_input_conditioner                                            |
// | Scoreboard bench: polling, hysteresis, repeat, buttons, reset.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_jstk_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jstk_input_conditioner_if u_if ();

  jstk_input_conditioner #(
    .POLL_DIV       (200),
    .TIMEOUT_CYCLES (100),
    .DZ_ENTER       (16'h3000),
    .DZ_EXIT        (16'h2000),
    .REPEAT_DELAY   (3),
    .REPEAT_RATE    (2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [24:0] exp_q[$];
  logic [15:0] exp_count = 16'd0;
  logic [15:0] last_count = 16'd0;
  logic        prev_j = 1'b0;
  logic        prev_t = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected record: {count, dir, strobe, jp, jr, tp, tr}
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic bj, input logic bt,
                      input logic [3:0] dir_e, input logic str_e, input int hold = 1);
    logic [3:0] pulses;
    pulses = {bj & ~prev_j, ~bj & prev_j, bt & ~prev_t, ~bt & prev_t};
    prev_j = bj;
    prev_t = bt;
    exp_count = exp_count + 16'd1;
    exp_q.push_back({exp_count, dir_e, str_e, pulses});
    @(negedge clk);
    u_if.x_position  = x;
    u_if.y_position  = y;
    u_if.btn_jstk    = bj;
    u_if.btn_trigger = bt;
    u_if.data_valid  = 1'b1;
    repeat (hold) @(negedge clk);
    u_if.data_valid  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [24:0] e;
    if (reset) begin
      last_count = 16'd0;
    end else if (u_if.sample_count != last_count) begin
      last_count = u_if.sample_count;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_sample", u_if.sample_count, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("sample_count", u_if.sample_count, e[24:9]);
        check_eq("dir", u_if.dir, e[8:5]);
        check_eq("move_strobe", u_if.move_strobe, e[4]);
        check_eq("buttons", {u_if.jstk_press, u_if.jstk_release, u_if.trig_press, u_if.trig_release}, e[3:0]);
        check_eq("link_error_after_sample", u_if.link_error, 0);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  cyc;
    logic seen;
    reset = 1'b1;
    u_if.x_position = 16'h8000;
    u_if.y_position = 16'h8000;
    u_if.btn_jstk = 1'b0;
    u_if.btn_trigger = 1'b0;
    u_if.data_valid = 1'b0;
    u_if.read_in_progress = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_start_read", u_if.start_read, 0);
    check_eq("rst_dir", u_if.dir, 0);
    check_eq("rst_link_error", u_if.link_error, 0);
    check_eq("rst_sample_count", u_if.sample_count, 0);
    check_eq("rst_strobe", u_if.move_strobe, 0);
    reset = 1'b0;

    // Poll request lands 200 cycles after reset release
    cyc = 0;
    while (cyc < 1000) begin
      @(posedge clk); #1; cyc++;
      if (u_if.start_read) break;
    end
    check_eq("poll_start_cycle", cyc, 200);
    @(posedge clk); #1;
    check_eq("start_read_one_cycle", u_if.start_read, 0);
    cyc = 1;
    while (!u_if.link_error && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq("timeout_cycles", cyc, 100);
    check_eq("link_error_set", u_if.link_error, 1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 4'b0000, 1'b0);
    u_if.read_in_progress = 1'b1;

    // Hysteresis, right then left, level data_valid on one sample
    send(16'hB100, 16'h8000, 1'b0, 1'b0, 4'b0001, 1'b1);
    send(16'hA800, 16'h8000, 1'b0, 1'b0, 4'b0001, 1'b0);
    send(16'h9F00, 16'h8000, 1'b0, 1'b0, 4'b0000, 1'b0, 4);
    send(16'h4E00, 16'h8000, 1'b0, 1'b0, 4'b0010, 1'b1);
    send(16'h5800, 16'h8000, 1'b0, 1'b0, 4'b0010, 1'b0);
    send(16'h6100, 16'h8000, 1'b0, 1'b0, 4'b0000, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 4'b1001, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Sign flip straight across
    send(16'hFFFF, 16'h8000, 1'b0, 1'b0, 4'b0001, 1'b1);
    send(16'h0000, 16'h8000, 1'b0, 1'b0, 4'b0010, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Auto-repeat: strobes at samples 1, 4, 6, 8
    for (int i = 1; i <= 8; i++)
      send(16'h8000, 16'h0000, 1'b0, 1'b0, 4'b0100,
           (i == 1 || i == 4 || i == 6 || i == 8) ? 1'b1 : 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Buttons: both press, trigger release, then joystick release
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 4'b0000, 1'b0);
    send(16'h8000, 16'h8000, 1'b1, 1'b1, 4'b0000, 1'b0);
    send(16'h8000, 16'h8000, 1'b1, 1'b0, 4'b0000, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 4'b0000, 1'b0);

    send(16'hFFFF, 16'h8000, 1'b0, 1'b0, 4'b0001, 1'b1);

    // Busy link holds off the request
    seen = 1'b0;
    repeat (450) begin
      @(negedge clk);
      if (u_if.start_read) seen = 1'b1;
    end
    check_eq("busy_no_start", seen, 0);
    u_if.read_in_progress = 1'b0;
    @(negedge clk);
    check_eq("start_after_busy", u_if.start_read, 1);
    @(negedge clk);
    check_eq("start_after_busy_drop", u_if.start_read, 0);

    // Reset while waiting for data
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_start_read", u_if.start_read, 0);
    check_eq("midrst_dir", u_if.dir, 0);
    check_eq("midrst_link_error", u_if.link_error, 0);
    check_eq("midrst_sample_count", u_if.sample_count, 0);
    exp_count = 16'd0;
    prev_j = 1'b0;
    prev_t = 1'b0;
    reset = 1'b0;
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 4'b0000, 1'b0);

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
